// File: rtl/mcycle_muldiv_if.sv
// Request/response bundle between the RV32 core and the mcycle_muldiv unit.
interface mcycle_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;

  modport master (output Start, MCycleOp, Operand1, Operand2, input Result, Busy, Done);
  modport slave  (input Start, MCycleOp, Operand1, Operand2, output Result, Busy, Done);
endinterface

// File: rtl/mcycle_muldiv.sv
// Iterative RV32 M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MCYCLE_EARLY_OUT_EN: zero multiplies and division corner cases finish on the accepting edge.
module mcycle_muldiv #(
  parameter int WIDTH = 32
) (
  input logic            CLK,
  input logic            Reset,
  mcycle_muldiv_if.slave bus
);
  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [1:0]      S_IDLE    = 2'd0;
  localparam logic [1:0]      S_COMPUTE = 2'd1;
  localparam logic [1:0]      S_FINAL   = 2'd2;
  localparam logic [1:0]      S_DONE    = 2'd3;
  localparam logic [2:0]      OP_MUL    = 3'b000;
  localparam logic [2:0]      OP_MULH   = 3'b001;
  localparam logic [2:0]      OP_MULHSU = 3'b010;
  localparam logic [2:0]      OP_MULHU  = 3'b011;
  localparam logic [2:0]      OP_DIV    = 3'b100;
  localparam logic [2:0]      OP_DIVU   = 3'b101;
  localparam logic [2:0]      OP_REM    = 3'b110;
  localparam logic [2:0]      OP_REMU   = 3'b111;
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s, sgn1_s, sgn2_s;
  logic [WIDTH-1:0]   abs1_s, abs2_s, final_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // Operand sign decode and magnitudes for the request on the bus
  always_comb begin
    accept_s = bus.Start && ((state_q == S_IDLE) || (state_q == S_DONE));
    case (bus.MCycleOp)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn1_s = bus.Operand1[WIDTH-1];
        sgn2_s = bus.Operand2[WIDTH-1];
      end
      OP_MULHSU: begin
        sgn1_s = bus.Operand1[WIDTH-1];
        sgn2_s = 1'b0;
      end
      default: begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
      end
    endcase
    abs1_s = sgn1_s ? neg_w(bus.Operand1) : bus.Operand1;
    abs2_s = sgn2_s ? neg_w(bus.Operand2) : bus.Operand2;
  end

  // Per-iteration datapath and the sign/corner-case fixup applied in FINAL
  always_comb begin
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_q, prod_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, a_q};
    prod_fix_s  = neg_q ? neg_2w(prod_q) : prod_q;
    case (op_q)
      OP_MUL:                       final_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_s = dz_q ? ONES : (neg_q ? neg_w(prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0]);
      OP_REM, OP_REMU:              final_s = dz_q ? op1_q : (neg_rem_q ? neg_w(rem_q) : rem_q);
      default:                      final_s = ZERO;
    endcase
  end

`ifdef MCYCLE_EARLY_OUT_EN
  logic             special_s;
  logic [WIDTH-1:0] special_val_s;

  // Requests whose result is known without iterating
  always_comb begin
    special_s     = 1'b0;
    special_val_s = ZERO;
    if (bus.MCycleOp[2]) begin
      if (bus.Operand2 == ZERO) begin
        special_s     = 1'b1;
        special_val_s = bus.MCycleOp[1] ? bus.Operand1 : ONES;
      end else if (!bus.MCycleOp[0] && (bus.Operand1 == MOST_NEG) && (bus.Operand2 == ONES)) begin
        special_s     = 1'b1;
        special_val_s = bus.MCycleOp[1] ? ZERO : MOST_NEG;
      end else begin
        special_s = 1'b0;
      end
    end else if ((bus.Operand1 == ZERO) || (bus.Operand2 == ZERO)) begin
      special_s     = 1'b1;
      special_val_s = ZERO;
    end else begin
      special_s = 1'b0;
    end
  end
`endif

  // Sequencer: accept, iterate WIDTH times, fix up, publish
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    op1_d     = op1_q;
    a_d       = a_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          op_d      = bus.MCycleOp;
          op1_d     = bus.Operand1;
          neg_d     = sgn1_s ^ sgn2_s;
          neg_rem_d = sgn1_s;
          dz_d      = (bus.Operand2 == ZERO);
          cnt_d     = {CW{1'b0}};
          rem_d     = ZERO;
          // Divide keeps the divisor in a_q and shifts the dividend out of prod_q
          if (bus.MCycleOp[2]) begin
            a_d    = abs2_s;
            prod_d = {ZERO, abs1_s};
          end else begin
            a_d    = abs1_s;
            prod_d = {ZERO, abs2_s};
          end
          state_d = S_COMPUTE;
          busy_d  = 1'b1;
`ifdef MCYCLE_EARLY_OUT_EN
          if (special_s) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = special_val_s;
          end else begin
            state_d = S_COMPUTE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (op_q[2]) begin
          rem_d  = div_trial_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
          prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~div_trial_s[WIDTH]};
        end else begin
          prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_FINAL: begin
        state_d  = S_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = final_s;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 3'b000;
      op1_q     <= ZERO;
      a_q       <= ZERO;
      prod_q    <= {(2*WIDTH){1'b0}};
      rem_q     <= ZERO;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      a_q       <= a_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
endmodule

// File: tb/tb_mcycle_muldiv.sv
// Scoreboard bench for mcycle_muldiv: WIDTH=32 main instance plus a WIDTH=8 instance.
module tb_mcycle_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcycle_muldiv_if #(.WIDTH(32)) bus ();
  mcycle_muldiv_if #(.WIDTH(8))  bus8 ();

  mcycle_muldiv #(.WIDTH(32)) dut  (.CLK(clk), .Reset(rst), .bus(bus));
  mcycle_muldiv #(.WIDTH(8))  dut8 (.CLK(clk), .Reset(rst), .bus(bus8));

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          busy;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   busy_cnt    = 0;
  int   done_cnt    = 0;
  int   exp_done    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference built on native SystemVerilog arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})); return p[63:32]; end
      3'd2: begin p = 64'($signed({{32{a[31]}}, a}) * $signed({32'h0, b})); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 32'h0) || (b == 32'h0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every Done of the 32-bit instance
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cnt++;
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_val({mon_e.name, " result"},  bus.Result,       mon_e.res);
          check_val({mon_e.name, " latency"}, cyc - mon_e.t0,   mon_e.lat);
          check_val({mon_e.name, " busy"},    busy_cnt,         mon_e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive one request at a negedge; expected result comes from the caller
  task automatic launch(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.res  = exp;
    e.lat  = 33;
    e.busy = 33;
`ifdef MCYCLE_EARLY_OUT_EN
    if (is_special(op, a, b)) begin
      e.lat  = 0;
      e.busy = 0;
    end
`endif
    e.t0 = cyc + 1;
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    sb_q.push_back(e);
    exp_done++;
    @(negedge clk);
    bus.Start    = 1'b0;
    bus.MCycleOp = 3'($urandom_range(7, 0));
    bus.Operand1 = $urandom();
    bus.Operand2 = $urandom();
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    launch(name, op, a, b, exp);
    drain();
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp);
    int t0;
    int n = 0;
    t0 = cyc + 1;
    bus8.Start    = 1'b1;
    bus8.MCycleOp = op;
    bus8.Operand1 = a;
    bus8.Operand2 = b;
    @(negedge clk);
    bus8.Start = 1'b0;
    while (!bus8.Done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({name, " result"},  {24'h0, bus8.Result}, {24'h0, exp});
    check_val({name, " latency"}, cyc - t0,             32'd9);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          n;
    rst = 1'b1;
    bus.Start = 1'b0;  bus.MCycleOp = 3'd0;  bus.Operand1 = 32'h0;  bus.Operand2 = 32'h0;
    bus8.Start = 1'b0; bus8.MCycleOp = 3'd0; bus8.Operand1 = 8'h0;  bus8.Operand2 = 8'h0;
    repeat (3) @(negedge clk);
    check_val("reset Result", bus.Result, 32'h0);
    check_val("reset Busy",   {31'h0, bus.Busy}, 32'h0);
    check_val("reset Done",   {31'h0, bus.Done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run("MUL",       3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("MULH",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("MULHU",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("MULHSU",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("DIV",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run("REM",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run("DIVU",      3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
    run("REMU",      3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);
    run("DIV_by0",   3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    run("REM_by0",   3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    run("DIV_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("REM_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run("MUL_zero",  3'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
    run("MULH_neg",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);

    // Start pulsed mid-operation must be ignored
    launch("DIVU_ign", 3'd5, 32'd1000, 32'd7, 32'd142);
    repeat (4) @(negedge clk);
    bus.Start = 1'b1; bus.MCycleOp = 3'd0; bus.Operand1 = 32'd3; bus.Operand2 = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    drain();

    // Back-to-back: second Start lands in the DONE cycle
    launch("MULHU_b2b1", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
    n = 0;
    while (!bus.Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("b2b done_seen", {31'h0, bus.Done}, 32'h1);
    launch("REMU_b2b2", 3'd7, 32'd1000, 32'd7, 32'd6);
    drain();

    // Reset ten cycles into a DIV aborts it silently
    launch("DIV_abort", 3'd4, 32'd100, 32'd7, 32'd14);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    exp_done--;
    @(negedge clk);
    check_val("abort Busy",   {31'h0, bus.Busy}, 32'h0);
    check_val("abort Done",   {31'h0, bus.Done}, 32'h0);
    check_val("abort Result", bus.Result, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run("DIV_after", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = $urandom();
      rb  = (i % 5 == 3) ? 32'h0 : $urandom() >> $urandom_range(31, 0);
      run($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    run8("W8_DIVU", 3'd5, 8'd200, 8'd7, 8'd28);
    run8("W8_REMU", 3'd7, 8'd200, 8'd7, 8'd4);
    run8("W8_DIV",  3'd4, 8'hF9,  8'd2, 8'hFD);

    repeat (5) @(negedge clk);
    check_val("done_count", done_cnt, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end
endmodule
